// File: rtl/div_pkg.sv
// Shared types, constants and helpers for the sequential restoring divider.
// Holds the FSM state encoding, the legal quotient-bits-per-cycle set and the
// iteration count helper used to size the CALC phase.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Quotient bits retired per cycle that the step chain supports.
  localparam int LEGAL_BPC [3] = '{1, 2, 4};

  // Number of CALC cycles needed to retire all quotient bits.
  function automatic int iter_count(input int width, input int bpc);
    return (bpc > 0) ? (width / bpc) : 0;
  endfunction

  // True when bpc is one of the supported per-cycle step counts.
  function automatic bit bpc_is_legal(input int bpc);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (LEGAL_BPC[i] == bpc) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift {rem,quo} left, subtract divisor if it fits.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  // Compare WIDTH+1 bits wide so a shifted remainder with its top bit set is
  // still ordered correctly against large divisors. Because rem < divisor on
  // entry, the borrow out of the subtraction is exactly "divisor does not fit".
  always_comb begin
    w_rem_sh = {i_rem, i_quo[WIDTH-1]};
    w_diff   = w_rem_sh - {1'b0, i_dvs};
    w_fits   = ~w_diff[WIDTH];
    o_rem    = w_fits ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    o_quo    = {i_quo[WIDTH-2:0], w_fits};
  end

endmodule

// File: rtl/div_seq_param.sv
// Parametrised multi-cycle restoring divider (signed/unsigned, BITS_PER_CYCLE steps per cycle).
// Latency: finish rises WIDTH/BITS_PER_CYCLE+1 non-stalled edges after start is accepted
// (1 edge for a zero divisor when DIV_ZERO_EARLY_EN is defined). Backpressure: cpu_stall freezes all state.
module div_seq_param
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cpu_stall,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             finish,
  output logic             div_zero
);

  localparam int ITER  = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int CNT_W = $clog2(ITER + 1);

  if (!bpc_is_legal(BITS_PER_CYCLE) || (WIDTH < 4) || ((WIDTH % 2) != 0) ||
      ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("div_seq_param: illegal WIDTH / BITS_PER_CYCLE combination");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_sign_dnd;
  logic             r_sign_vsr;
  logic [WIDTH-1:0] r_dnd_raw;
  logic [WIDTH-1:0] r_vsr_mag;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [CNT_W-1:0] r_cnt;

  logic             w_sign_dnd;
  logic             w_sign_vsr;
  logic [WIDTH-1:0] w_dnd_mag;
  logic [WIDTH-1:0] w_vsr_mag;
  logic             w_vsr_zero;
  logic             w_last_iter;
  logic [WIDTH-1:0] w_rem [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] w_quo [BITS_PER_CYCLE+1];

  // Operand sign capture and magnitude formation at issue; signs are 0 in unsigned mode.
  always_comb begin
    w_sign_dnd  = is_signed & dividend[WIDTH-1];
    w_sign_vsr  = is_signed & divisor[WIDTH-1];
    w_dnd_mag   = w_sign_dnd ? -dividend : dividend;
    w_vsr_mag   = w_sign_vsr ? -divisor : divisor;
    w_vsr_zero  = (r_vsr_mag == '0);
    w_last_iter = (r_cnt == CNT_W'(ITER - 1));
  end

  assign w_rem[0] = r_rem;
  assign w_quo[0] = r_quo;

  for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .i_rem (w_rem[g]),
      .i_quo (w_quo[g]),
      .i_dvs (r_vsr_mag),
      .o_rem (w_rem[g+1]),
      .o_quo (w_quo[g+1])
    );
  end

  // State register; a stalled cycle simply keeps the current state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: issue from IDLE, run ITER CALC cycles, one FIX cycle, back to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (!cpu_stall) begin
      case (r_state)
        IDLE: begin
          if (start) begin
`ifdef DIV_ZERO_EARLY_EN
            w_state_nxt = (divisor == '0) ? FIX : CALC;
`else
            w_state_nxt = CALC;
`endif
          end
        end
        CALC:    if (w_last_iter) w_state_nxt = FIX;
        FIX:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Datapath and handshake: latch on issue, iterate in CALC, sign-fix and publish in FIX.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sign_dnd <= 1'b0;
      r_sign_vsr <= 1'b0;
      r_dnd_raw  <= '0;
      r_vsr_mag  <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_cnt      <= '0;
      q          <= '0;
      r          <= '0;
      busy       <= 1'b0;
      finish     <= 1'b0;
      div_zero   <= 1'b0;
    end else if (!cpu_stall) begin
      finish <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sign_dnd <= w_sign_dnd;
            r_sign_vsr <= w_sign_vsr;
            r_dnd_raw  <= dividend;
            r_vsr_mag  <= w_vsr_mag;
            r_rem      <= '0;
            r_quo      <= w_dnd_mag;
            r_cnt      <= '0;
            busy       <= 1'b1;
          end
        end
        CALC: begin
          r_rem <= w_rem[BITS_PER_CYCLE];
          r_quo <= w_quo[BITS_PER_CYCLE];
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          // Zero divisor: all-ones quotient, dividend passed through as remainder.
          if (w_vsr_zero) begin
            q <= '1;
            r <= r_dnd_raw;
          end else begin
            q <= (r_sign_dnd ^ r_sign_vsr) ? -r_quo : r_quo;
            r <= r_sign_dnd ? -r_rem : r_rem;
          end
          div_zero <= w_vsr_zero;
          finish   <= 1'b1;
          busy     <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_param.sv
module tb_div_seq_param;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start4 = 1'b0;
  logic        is_signed = 1'b0;
  logic        cpu_stall = 1'b0;
  logic        stall4 = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] q, r, q4, r4;
  logic        busy, finish, div_zero;
  logic        busy4, finish4, div_zero4;

  int total = 0;
  int bad   = 0;

`ifdef DIV_ZERO_EARLY_EN
  localparam int LAT_DZ = 1;
`else
  localparam int LAT_DZ = 33;
`endif

  always #5 clock = ~clock;

  div_seq_param #(.WIDTH(32), .BITS_PER_CYCLE(1)) u_dut (
    .clock(clock), .reset(reset), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .cpu_stall(cpu_stall),
    .q(q), .r(r), .busy(busy), .finish(finish), .div_zero(div_zero)
  );

  div_seq_param #(.WIDTH(32), .BITS_PER_CYCLE(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start4), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .cpu_stall(stall4),
    .q(q4), .r(r4), .busy(busy4), .finish(finish4), .div_zero(div_zero4)
  );

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
    logic        edz;
    int          elat;
  } vec_t;

  vec_t vt [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for finish; lat counts edges after the accepting edge.
  task automatic run_op(input bit use4, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] qo, output logic [31:0] ro,
                        output logic dz);
    @(negedge clock);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    if (use4) start4 = 1'b1;
    else      start  = 1'b1;
    @(posedge clock);
    #1;
    start  = 1'b0;
    start4 = 1'b0;
    lat    = 0;
    while (!(use4 ? finish4 : finish) && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
    end
    qo = use4 ? q4 : q;
    ro = use4 ? r4 : r;
    dz = use4 ? div_zero4 : div_zero;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int          lat;
    int          seen;
    logic [31:0] qo, ro;
    logic        dz;

    vt[0]  = '{1'b1, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
    vt[1]  = '{1'b1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33};
    vt[2]  = '{1'b1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33};
    vt[3]  = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0, 33};
    vt[4]  = '{1'b1, 32'hFFFFFFFF,   32'h10,         32'h0,          32'hFFFFFFFF,   1'b0, 33};
    vt[5]  = '{1'b0, 32'h1234,       32'h0,          32'hFFFFFFFF,   32'h1234,       1'b1, LAT_DZ};
    vt[6]  = '{1'b1, 32'h1234,       32'h0,          32'hFFFFFFFF,   32'h1234,       1'b1, LAT_DZ};
    vt[7]  = '{1'b1, 32'hFFFFFF00,   32'h0,          32'hFFFFFFFF,   32'hFFFFFF00,   1'b1, LAT_DZ};
    vt[8]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0,          1'b0, 33};
    vt[9]  = '{1'b0, 32'h80000000,   32'h80000000,   32'h1,          32'h0,          1'b0, 33};
    vt[10] = '{1'b0, 32'hFFFFFFFF,   32'h80000000,   32'h1,          32'h7FFFFFFF,   1'b0, 33};
    vt[11] = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'h3,          32'hFFFFFFFF,   1'b0, 33};
    vt[12] = '{1'b0, 32'd7,          32'd9,          32'h0,          32'd7,          1'b0, 33};

    // Reset state, sampled while reset is still asserted.
    repeat (2) @(posedge clock);
    #1;
    check("rst.q", q, 32'h0);
    check("rst.r", r, 32'h0);
    check("rst.busy", {31'b0, busy}, 32'h0);
    check("rst.finish", {31'b0, finish}, 32'h0);
    check("rst.div_zero", {31'b0, div_zero}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Table-driven vectors; consecutive ops are issued back-to-back on the finish edge.
    for (int i = 0; i < 13; i++) begin
      run_op(1'b0, vt[i].sgn, vt[i].a, vt[i].b, lat, qo, ro, dz);
      check($sformatf("v%0d.q", i), qo, vt[i].eq);
      check($sformatf("v%0d.r", i), ro, vt[i].er);
      check($sformatf("v%0d.dz", i), {31'b0, dz}, {31'b0, vt[i].edz});
      check($sformatf("v%0d.lat", i), 32'(lat), 32'(vt[i].elat));
    end

    // Start presented while stalled in IDLE must not be accepted.
    @(negedge clock);
    cpu_stall = 1'b1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd9; divisor = 32'd3;
    @(posedge clock); #1;
    check("idle_stall.busy", {31'b0, busy}, 32'h0);
    @(negedge clock);
    start = 1'b0;
    cpu_stall = 1'b0;
    @(posedge clock); #1;
    check("idle_stall.busy2", {31'b0, busy}, 32'h0);

    // 5-cycle stall mid-CALC: finish moves from edge 33 to edge 38.
    @(negedge clock);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!finish && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 10) cpu_stall = 1'b1;
      if (lat == 15) cpu_stall = 1'b0;
    end
    check("stall.lat", 32'(lat), 32'd38);
    check("stall.q", q, 32'd14);
    check("stall.r", r, 32'd2);

    // finish held through a stall, cleared on the first free edge.
    cpu_stall = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("hold.finish", {31'b0, finish}, 32'h1);
    check("hold.q", q, 32'd14);
    cpu_stall = 1'b0;
    @(posedge clock); #1;
    check("hold.clear", {31'b0, finish}, 32'h0);

    // Start while busy is ignored and the in-flight operands are unaffected.
    @(negedge clock);
    start = 1'b1; is_signed = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!finish && lat < 100) begin
      @(posedge clock); #1;
      lat++;
      if (lat == 5) begin
        start = 1'b1; is_signed = 1'b0; dividend = 32'd50; divisor = 32'd5;
      end
      if (lat == 6) start = 1'b0;
    end
    check("busy_start.lat", 32'(lat), 32'd33);
    check("busy_start.q", q, 32'd14);
    check("busy_start.r", r, 32'd2);
    repeat (2) @(posedge clock);
    #1;
    check("busy_start.noqueue", {31'b0, busy}, 32'h0);

    // Reset 10 cycles into an operation: outputs cleared, no finish afterwards.
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd77; divisor = 32'd5;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst.q", q, 32'h0);
    check("mid_rst.r", r, 32'h0);
    check("mid_rst.busy", {31'b0, busy}, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock); #1;
      if (finish || busy) seen++;
    end
    check("mid_rst.nofinish", 32'(seen), 32'd0);

    // Four quotient bits per cycle: finish at edge 9.
    run_op(1'b1, 1'b1, 32'd100, 32'd7, lat, qo, ro, dz);
    check("bpc4.lat", 32'(lat), 32'd9);
    check("bpc4.q", qo, 32'd14);
    check("bpc4.r", ro, 32'd2);
    run_op(1'b1, 1'b1, 32'hFFFFFF9C, 32'd7, lat, qo, ro, dz);
    check("bpc4.neg.q", qo, 32'hFFFFFFF2);
    check("bpc4.neg.r", ro, 32'hFFFFFFFE);
    run_op(1'b1, 1'b0, 32'h1234, 32'h0, lat, qo, ro, dz);
    check("bpc4.dz.q", qo, 32'hFFFFFFFF);
    check("bpc4.dz.r", ro, 32'h1234);
    check("bpc4.dz.flag", {31'b0, dz}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
